// File: rtl/mant_mul_pkg.sv
// mant_mul_pkg: shared types and constants for the sequential mantissa multiplier
// Provides:
//   state_t      - FSM state encoding {IDLE, RUN, DONE}
//   DEF_MANT_W   - default mantissa width (hidden bit included)
//   DEF_CNT_W    - bit counter width for the default mantissa width
//   cnt_width()  - bit counter width for any mantissa width
package mant_mul_pkg;
    localparam int DEF_MANT_W = 24;
    localparam int DEF_CNT_W  = $clog2(DEF_MANT_W + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/mant_mul_step.sv
// mant_mul_step: one shift-add step of the multiplier, combinational
// Ports:
//   p      [2*MANT_W:0] - current partial product / remaining multiplier bits
//   a      [MANT_W-1:0] - multiplicand
//   p_next [2*MANT_W:0] - P after the conditional add of A and a 1-bit right shift
module mant_mul_step
    import mant_mul_pkg::*;
#(
    parameter int MANT_W = DEF_MANT_W
) (
    input  logic [2*MANT_W:0] p,
    input  logic [MANT_W-1:0] a,
    output logic [2*MANT_W:0] p_next
);
    logic [MANT_W:0] hi;
    always_comb begin
        // the (MANT_W+1)-bit upper half keeps the carry of the add
        hi     = p[2*MANT_W:MANT_W] + (p[0] ? {1'b0, a} : '0);
        p_next = {1'b0, hi, p[MANT_W-1:1]};
    end
endmodule

// File: rtl/mant_mul_seq.sv
// mant_mul_seq: sequential shift-add multiplier for normalised mantissas, one bit per clock
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   in_start          - request, accepted in IDLE or DONE
//   in_multiplicand   - operand A, sampled on the accepting edge
//   in_multiplier     - operand B, sampled on the accepting edge
//   out_busy          - high while the multiply runs
//   out_valid         - one-cycle pulse when out_product is final
//   out_product       - A*B, held until the next accepted start
// Option: define MANT_MUL_EARLY_EXIT_EN to finish as soon as the remaining
// multiplier bits are all zero (latency = position of B's top set bit, min 1).
module mant_mul_seq
    import mant_mul_pkg::*;
#(
    parameter int MANT_W = DEF_MANT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_start,
    input  logic [MANT_W-1:0]     in_multiplicand,
    input  logic [MANT_W-1:0]     in_multiplier,
    output logic                  out_busy,
    output logic                  out_valid,
    output logic [2*MANT_W-1:0]   out_product
);
    localparam int CNT_W = cnt_width(MANT_W);
    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [MANT_W-1:0]   a_q;
    logic [2*MANT_W:0]   p, p_step, p_run;
    logic                last;
    mant_mul_step #(.MANT_W(MANT_W)) u_step (
        .p      (p),
        .a      (a_q),
        .p_next (p_step)
    );
`ifdef MANT_MUL_EARLY_EXIT_EN
    logic [MANT_W-1:0] rem_mask;
    logic              rest_zero;
    always_comb begin
        // low MANT_W-cnt bits of P are still multiplier bits; bit 0 is handled by this step
        rem_mask  = {MANT_W{1'b1}} >> cnt;
        rest_zero = ((p[MANT_W-1:0] & rem_mask) >> 1) == '0;
        last      = rest_zero || cnt == CNT_W'(MANT_W - 1);
        // skip the remaining all-zero bits: total shift this cycle is MANT_W-cnt
        p_run     = rest_zero ? p_step >> (CNT_W'(MANT_W - 1) - cnt) : p_step;
    end
`else
    always_comb begin
        last  = cnt == CNT_W'(MANT_W - 1);
        p_run = p_step;
    end
`endif
    assign out_product = p[2*MANT_W-1:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a_q       <= '0;
            p         <= '0;
            out_busy  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == RUN) begin
                p   <= p_run;
                cnt <= cnt + 1'b1;
                if (last) begin
                    state     <= DONE;
                    out_busy  <= 1'b0;
                    out_valid <= 1'b1;
                end
            end else if (in_start) begin
                a_q      <= in_multiplicand;
                p        <= {{(MANT_W + 1){1'b0}}, in_multiplier};
                cnt      <= '0;
                state    <= RUN;
                out_busy <= 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule
